// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: buffered multi-issue fetch stage with redirect flush
module instruction_fetch_unit #(
    parameter int XLEN        = 32,
    parameter int IMEM_DEPTH  = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int BUF_DEPTH   = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            imem_req,
    output logic [$clog2(IMEM_DEPTH)-1:0]   imem_addr,
    input  logic [FETCH_WIDTH*XLEN-1:0]     imem_rdata,
    input  logic                            redirect_valid,
    input  logic [$clog2(IMEM_DEPTH)-1:0]   redirect_pc,
    output logic [1:0]                      out_valid,
    output logic [XLEN-1:0]                 out_instr0,
    output logic [XLEN-1:0]                 out_instr1,
    output logic [$clog2(IMEM_DEPTH)-1:0]   out_pc0,
    output logic [$clog2(IMEM_DEPTH)-1:0]   out_pc1,
    input  logic [1:0]                      deq_count
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [AW-1:0]   fetch_pc;
    logic [AW-1:0]   inflight_pc;
    logic            inflight;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [AW-1:0]   pc_buf [BUF_DEPTH];
    logic [XLEN-1:0] instr_buf [BUF_DEPTH];
    logic            enq;
    logic [1:0]      deq;
    logic [PW-1:0]   head1;

    // Circular pointer advance; steps never exceed BUF_DEPTH so one subtraction wraps
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        return PW'((s >= BUF_DEPTH) ? s - BUF_DEPTH : s);
    endfunction

    // Request only when the buffer can absorb both the in-flight group and a new one
    always_comb begin
        imem_req = !rst && !redirect_valid &&
                   (int'(count) + (inflight ? FETCH_WIDTH : 0) + FETCH_WIDTH <= BUF_DEPTH);
        enq      = inflight && !redirect_valid;
        deq      = redirect_valid ? 2'd0 : deq_count;
        head1    = ptr_add(head, 1);
    end

    assign imem_addr  = fetch_pc;
    assign out_valid  = (count == '0) ? 2'b00 : (count == CW'(1)) ? 2'b01 : 2'b11;
    assign out_instr0 = instr_buf[head];
    assign out_instr1 = instr_buf[head1];
    assign out_pc0    = pc_buf[head];
    assign out_pc1    = pc_buf[head1];

    // Control state: fetch pointer, in-flight tracking, buffer occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= AW'(RESET_PC);
            inflight_pc <= '0;
            inflight    <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (imem_req) begin
                fetch_pc    <= fetch_pc + AW'(FETCH_WIDTH);
                inflight_pc <= fetch_pc;
            end
            inflight <= imem_req;
            if (enq)
                tail <= ptr_add(tail, FETCH_WIDTH);
            head  <= ptr_add(head, int'(deq));
            count <= CW'(int'(count) + (enq ? FETCH_WIDTH : 0) - int'(deq));
        end
    end

    // Buffer storage: append the returning group at the tail, PCs wrap within the group
    always_ff @(posedge clk) begin
        if (!rst && enq)
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                pc_buf[ptr_add(tail, k)]    <= inflight_pc + AW'(k);
                instr_buf[ptr_add(tail, k)] <= imem_rdata[k*XLEN +: XLEN];
            end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of fetch, backpressure, drain, redirect, wrap, reset
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [4:0]  redirect_pc = '0;
    logic [1:0]  deq_count = '0;
    logic        imem_req;
    logic [4:0]  imem_addr;
    logic [63:0] imem_rdata = '0;
    logic [1:0]  out_valid;
    logic [31:0] out_instr0, out_instr1;
    logic [4:0]  out_pc0, out_pc1;
    logic [31:0] mem [32];
    int          checks = 0;
    int          errors = 0;

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr0(out_instr0), .out_instr1(out_instr1),
        .out_pc0(out_pc0), .out_pc1(out_pc1), .deq_count(deq_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory returning two consecutive words, address wrapping
    always @(posedge clk)
        if (imem_req) imem_rdata <= {mem[imem_addr + 5'd1], mem[imem_addr]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rv, input logic [4:0] rp, input logic [1:0] d);
        @(posedge clk);
        #1;
        rst = r;
        redirect_valid = rv;
        redirect_pc = rp;
        deq_count = d;
        #1;
    endtask

    task automatic rst_seq();
        cyc(1'b1, 1'b0, 5'd0, 2'd0);
        cyc(1'b1, 1'b0, 5'd0, 2'd0);
        check("rst_req", imem_req, 0);
        check("rst_valid", out_valid, 0);
    endtask

    task automatic check_slots(input string tag, input logic [4:0] p0, input logic [4:0] p1);
        check({tag, "_valid"}, out_valid, 2'b11);
        check({tag, "_pc0"}, out_pc0, p0);
        check({tag, "_pc1"}, out_pc1, p1);
        check({tag, "_in0"}, out_instr0, mem[p0]);
        check({tag, "_in1"}, out_instr1, mem[p1]);
    endtask

    task automatic check_req(input string tag, input logic r, input logic [4:0] a);
        check({tag, "_req"}, imem_req, r);
        if (r) check({tag, "_addr"}, imem_addr, a);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hC000_0000 + i;
        mem[0] = 32'h12345678; mem[1] = 32'h9ABCDEF0; mem[2] = 32'h0F0F0F0F;
        mem[3] = 32'hF0F0F0F0; mem[4] = 32'hAAAAAAAA; mem[5] = 32'h55555555;

        // Reset fetch
        rst_seq();
        cyc(0, 0, 0, 0); check_req("t1c0", 1, 0); check("t1c0_valid", out_valid, 0);
        cyc(0, 0, 0, 0); check_req("t1c1", 1, 2); check("t1c1_valid", out_valid, 0);
        cyc(0, 0, 0, 2); check_slots("t1c2", 0, 1); check_req("t1c2", 0, 0);
        cyc(0, 0, 0, 2); check_slots("t1c3", 2, 3); check_req("t1c3", 1, 4);
        cyc(0, 0, 0, 0); check("t1c4_valid", out_valid, 0);
        cyc(0, 0, 0, 2); check_slots("t1c5", 4, 5);

        // Backpressure
        rst_seq();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0); check_slots("t2c3", 0, 1); check_req("t2c3", 0, 0);
        cyc(0, 0, 0, 0); check_slots("t2c4", 0, 1); check_req("t2c4", 0, 0);
        cyc(0, 0, 0, 1); check_slots("t2c5", 0, 1);
        cyc(0, 0, 0, 0); check_slots("t2c6", 1, 2); check_req("t2c6", 0, 0);
        cyc(0, 0, 0, 1); check_req("t2c7", 0, 0);
        cyc(0, 0, 0, 0); check_slots("t2c8", 2, 3); check_req("t2c8", 1, 4);

        // Single-issue drain: one instruction per cycle, 01 whenever one entry remains
        rst_seq();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 1);
            check("t3_pc0", out_pc0, 5'(i));
            check("t3_in0", out_instr0, mem[i]);
            check("t3_valid", out_valid, (i >= 3 && i % 2 == 1) ? 2'b01 : 2'b11);
        end

        // Redirect while the 4/5 group is returning
        rst_seq();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 2);
        cyc(0, 0, 0, 2);
        cyc(0, 1, 20, 0); check_req("t4c4", 0, 0);
        cyc(0, 0, 0, 0); check("t4c5_valid", out_valid, 0); check_req("t4c5", 1, 20);
        cyc(0, 0, 0, 0); check("t4c6_valid", out_valid, 0); check_req("t4c6", 1, 22);
        cyc(0, 0, 0, 2); check_slots("t4c7", 20, 21);

        // Group wrapping past the top of memory
        rst_seq();
        cyc(0, 1, 31, 0); check_req("t5c0", 0, 0);
        cyc(0, 0, 0, 0); check_req("t5c1", 1, 31);
        cyc(0, 0, 0, 0); check_req("t5c2", 1, 1); check("t5c2_valid", out_valid, 0);
        cyc(0, 0, 0, 2); check_slots("t5c3", 31, 0);
        cyc(0, 0, 0, 2); check_slots("t5c4", 1, 2);

        // Reset while a response is arriving
        rst_seq();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0); check_req("t6r", 0, 0);
        cyc(0, 0, 0, 0); check("t6c0_valid", out_valid, 0); check_req("t6c0", 1, 0);
        cyc(0, 0, 0, 0); check("t6c1_valid", out_valid, 0); check_req("t6c1", 1, 2);
        cyc(0, 0, 0, 2); check_slots("t6c2", 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
